// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit-port arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        HOLD     = 2'd2
    } arb_state_e;

    localparam logic [7:0] DEF_EOL_CHAR = 8'h0A;
    localparam int         OWNER_W      = 3;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index after i_last, wrapping
// modulo N. Kept standalone so other arbiters can reuse it.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_pend,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_pick
);

    // Scan offsets from farthest to nearest so the nearest pending source wins.
    always_comb begin
        o_valid = 1'b0;
        o_pick  = '0;
        for (int k = N; k >= 1; k--) begin
            for (int j = 0; j < N; j++) begin
                if ((j == ((int'(i_last) + k) % N)) && i_pend[j]) begin
                    o_valid = 1'b1;
                    o_pick  = IDX_W'(j);
                end else begin
                    o_valid = o_valid;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the toggle-handshake UART transmit port between NUM_REQ byte sources.
// A granted source keeps the port until it sends EOL_CHAR or goes idle for
// HOLD_TIMEOUT cycles, so lines from different sources never interleave.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_REQ      = 3,
    parameter logic [7:0] EOL_CHAR     = DEF_EOL_CHAR,
    parameter int         HOLD_TIMEOUT = 4096,
    parameter int         TMR_W        = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [7:0]             txdata,
    output logic                   txreq,
    input  logic                   txack,
    output logic [OWNER_W-1:0]     owner,
    output logic                   locked
);

    arb_state_e         r_state;
    logic [NUM_REQ-1:0] r_ack;
    logic [7:0]         r_txdata;
    logic               r_txreq;
    logic [OWNER_W-1:0] r_owner;
    logic [OWNER_W-1:0] r_last;
    logic [TMR_W-1:0]   r_timer;
    logic               r_locked;
    logic               r_eol;

    logic [NUM_REQ-1:0] w_pend;
    logic               w_rr_valid;
    logic [OWNER_W-1:0] w_rr_pick;
    logic [OWNER_W-1:0] w_sel;
    logic [7:0]         w_sel_data;
    logic [NUM_REQ-1:0] w_sel_mask;
    logic               w_own_pend;
    logic               w_launch;

    assign w_pend = req ^ r_ack;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (OWNER_W)
    ) u_rr_pick (
        .i_pend  (w_pend),
        .i_last  (r_last),
        .o_valid (w_rr_valid),
        .o_pick  (w_rr_pick)
    );

    // Select the source to launch: the owner while holding, else the rr pick.
    always_comb begin
        w_sel      = (r_state == HOLD) ? r_owner : w_rr_pick;
        w_sel_data = 8'h00;
        w_sel_mask = '0;
        w_own_pend = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == OWNER_W'(i)) begin
                w_sel_data    = data[8*i +: 8];
                w_sel_mask[i] = 1'b1;
            end else begin
                w_sel_mask[i] = 1'b0;
            end
            if (r_owner == OWNER_W'(i)) begin
                w_own_pend = w_pend[i];
            end else begin
                w_own_pend = w_own_pend;
            end
        end
        if (r_state == IDLE) begin
            w_launch = w_rr_valid;
        end else if (r_state == HOLD) begin
            w_launch = w_own_pend;
        end else begin
            w_launch = 1'b0;
        end
    end

    // Grant FSM: launch bytes, wait for UART completion, hold or release the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack    <= req;
            r_txreq  <= txack;
            r_txdata <= 8'h00;
            r_owner  <= '0;
            r_last   <= OWNER_W'(NUM_REQ - 1);
            r_timer  <= '0;
            r_state  <= IDLE;
            r_locked <= 1'b0;
            r_eol    <= 1'b0;
        end else if (w_launch) begin
            // A launch beats a coinciding hold timeout.
            r_owner  <= w_sel;
            r_txdata <= w_sel_data;
            r_txreq  <= ~txack;
            r_ack    <= (r_ack & ~w_sel_mask) | (req & w_sel_mask);
            r_eol    <= (w_sel_data == EOL_CHAR);
            r_timer  <= '0;
            r_state  <= WAIT_ACK;
            r_locked <= 1'b1;
        end else begin
            case (r_state)
                WAIT_ACK: begin
                    // No timeout here: a full UART FIFO may stall us indefinitely.
                    if (txack == r_txreq) begin
                        if (r_eol || (HOLD_TIMEOUT == 0)) begin
                            r_last   <= r_owner;
                            r_state  <= IDLE;
                            r_locked <= 1'b0;
                        end else begin
                            r_timer  <= '0;
                            r_state  <= HOLD;
                            r_locked <= 1'b1;
                        end
                    end else begin
                        r_state <= WAIT_ACK;
                    end
                end
                HOLD: begin
                    // Timer stops at its release value rather than wrapping.
                    if (r_timer == TMR_W'(HOLD_TIMEOUT - 1)) begin
                        r_last   <= r_owner;
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                IDLE: begin
                    r_state  <= IDLE;
                    r_locked <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign ack    = r_ack;
    assign txdata = r_txdata;
    assign txreq  = r_txreq;
    assign owner  = r_owner;
    assign locked = r_locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a toggle-handshake UART model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [23:0] data = 24'h0;
    logic [2:0]  ack;
    logic [7:0]  txdata;
    logic        txreq;
    logic        txack = 1'b0;
    logic [2:0]  owner;
    logic        locked;

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] exp_q[$];
    logic [10:0] rx_q[$];

    bit stall = 1'b0;
    bit u_busy = 1'b0;
    int u_cnt = 0;

    uart_tx_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .data   (data),
        .ack    (ack),
        .txdata (txdata),
        .txreq  (txreq),
        .txack  (txack),
        .owner  (owner),
        .locked (locked)
    );

    always #5 clk = ~clk;

    // UART model: records each launched byte, acknowledges 3 cycles later unless stalled.
    always @(negedge clk) begin
        if (reset) begin
            u_busy = 1'b0;
        end else if (!u_busy) begin
            if (txreq !== txack) begin
                u_busy = 1'b1;
                u_cnt  = 3;
                rx_q.push_back({owner, txdata});
            end
        end else if (!stall) begin
            u_cnt = u_cnt - 1;
            if (u_cnt == 0) begin
                txack  = ~txack;
                u_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int src, input logic [7:0] b);
        data[8*src +: 8] = b;
        req[src] = ~req[src];
    endtask

    task automatic wait_txdone(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (txack === txreq) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_acked(input int src, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (ack[src] === req[src]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_settle(input int n, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (rx_q.size() >= n && locked === 1'b0 && txreq === txack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        req = 3'b101;
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++; if (ack !== req) begin n_bad++; $display("FAIL reset_ack: got %b want %b", ack, req); end
        n_cmp++; if (txreq !== txack) begin n_bad++; $display("FAIL reset_txreq: got %b want %b", txreq, txack); end
        n_cmp++; if (txdata !== 8'h00) begin n_bad++; $display("FAIL reset_txdata: got %h want 00", txdata); end
        n_cmp++; if (owner !== 3'd0 || locked !== 1'b0) begin n_bad++; $display("FAIL reset_owner_locked: got %0d/%b want 0/0", owner, locked); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        int hold;
        logic [10:0] e, g;
        exp_q.push_back({3'd1, 8'h41});
        send(1, 8'h41);
        tick();
        n_cmp++; if (ack[1] !== req[1]) begin n_bad++; $display("FAIL single_ack: got %b want %b", ack[1], req[1]); end
        n_cmp++; if (txreq === txack || txdata !== 8'h41) begin n_bad++; $display("FAIL single_launch: got txreq=%b txack=%b txdata=%h want toggle and 41", txreq, txack, txdata); end
        n_cmp++; if (locked !== 1'b1 || owner !== 3'd1) begin n_bad++; $display("FAIL single_lock: got %b/%0d want 1/1", locked, owner); end
        wait_txdone(20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_done: got timeout want txack==txreq"); end
        hold = 0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (locked !== 1'b1) break;
            hold++;
        end
        n_cmp++; if (hold != 4096) begin n_bad++; $display("FAIL single_hold: got %0d want 4096 locked cycles", hold); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL single_rx: got none want %h", e); end
            else begin g = rx_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL single_rx: got %h want %h", g, e); end end
        end
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL single_extra: got %0d extra want 0", rx_q.size()); end
        rx_q.delete();
    endtask

    task automatic test_line_lock();
        bit ok;
        logic [10:0] e, g;
        exp_q.push_back({3'd0, 8'h41});
        exp_q.push_back({3'd0, 8'h42});
        exp_q.push_back({3'd0, 8'h0A});
        exp_q.push_back({3'd2, 8'h5A});
        send(0, 8'h41);
        tick();
        send(2, 8'h5A);
        wait_acked(0, 20, ok);
        send(0, 8'h42);
        wait_acked(0, 50, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL line_ack0: got timeout want ack[0]==req[0]"); end
        send(0, 8'h0A);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rx_q.size() >= 3) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok || ack[2] === req[2]) begin n_bad++; $display("FAIL line_hold2: got ok=%b ack2=%b req2=%b want source 2 still pending", ok, ack[2], req[2]); end
        wait_settle(4, 6000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL line_settle: got timeout want idle"); end
        n_cmp++; if (ack[2] !== req[2]) begin n_bad++; $display("FAIL line_ack2: got %b want %b", ack[2], req[2]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL line_rx: got none want %h", e); end
            else begin g = rx_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL line_rx: got %h want %h", g, e); end end
        end
        rx_q.delete();
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [10:0] e, g;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.push_back({3'd0, 8'h0A});
        exp_q.push_back({3'd1, 8'h0A});
        exp_q.push_back({3'd2, 8'h0A});
        exp_q.push_back({3'd0, 8'h0A});
        send(0, 8'h0A);
        send(1, 8'h0A);
        send(2, 8'h0A);
        wait_acked(0, 20, ok);
        send(0, 8'h0A);
        wait_settle(4, 200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_settle: got timeout want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL rr_order: got none want %h", e); end
            else begin g = rx_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL rr_order: got %h want %h", g, e); end end
        end
        rx_q.delete();
    endtask

    task automatic test_timeout_vs_launch();
        bit ok;
        logic [10:0] e, g;
        exp_q.push_back({3'd1, 8'h31});
        exp_q.push_back({3'd1, 8'h32});
        exp_q.push_back({3'd2, 8'h0A});
        exp_q.push_back({3'd1, 8'h0A});
        send(1, 8'h31);
        wait_txdone(20, ok);
        send(2, 8'h0A);
        for (int n = 1; n <= 4096; n++) tick();
        send(1, 8'h32);
        tick();
        n_cmp++; if (locked !== 1'b1 || owner !== 3'd1 || ack[1] !== req[1]) begin n_bad++; $display("FAIL tmo_launch: got locked=%b owner=%0d ack1=%b want 1/1/%b", locked, owner, ack[1], req[1]); end
        n_cmp++; if (ack[2] === req[2] || txreq === txack) begin n_bad++; $display("FAIL tmo_no_release: got ack2=%b txreq=%b want pending/in-flight", ack[2], txreq); end
        wait_txdone(20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_done: got timeout want txack==txreq"); end
        for (int n = 1; n <= 4097; n++) tick();
        send(1, 8'h0A);
        tick();
        n_cmp++; if (owner !== 3'd2 || ack[1] === req[1] || locked !== 1'b1) begin n_bad++; $display("FAIL tmo_release_rr: got owner=%0d ack1=%b want 2 with source 1 pending", owner, ack[1]); end
        wait_settle(4, 200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_settle: got timeout want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL tmo_rx: got none want %h", e); end
            else begin g = rx_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL tmo_rx: got %h want %h", g, e); end end
        end
        rx_q.delete();
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        logic txreq_l;
        logic [10:0] e, g;
        exp_q.push_back({3'd0, 8'h0A});
        exp_q.push_back({3'd1, 8'h0A});
        stall = 1'b1;
        send(0, 8'h0A);
        tick();
        txreq_l = txreq;
        n_cmp++; if (txreq === txack || ack[0] !== req[0]) begin n_bad++; $display("FAIL bp_launch: got txreq=%b ack0=%b want toggled/acked", txreq, ack[0]); end
        send(1, 8'h0A);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (txreq !== txreq_l || locked !== 1'b1 || owner !== 3'd0 || ack[1] === req[1]) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_stall: got %0d bad cycles want 0", bad); end
        stall = 1'b0;
        wait_settle(2, 100, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_settle: got timeout want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL bp_rx: got none want %h", e); end
            else begin g = rx_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL bp_rx: got %h want %h", g, e); end end
        end
        rx_q.delete();
    endtask

    task automatic test_reset_mid();
        int bad;
        logic [10:0] e, g;
        exp_q.push_back({3'd1, 8'h55});
        stall = 1'b1;
        send(1, 8'h55);
        tick();
        send(0, 8'h66);
        send(2, 8'h77);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stall = 1'b0;
        n_cmp++; if (ack !== req) begin n_bad++; $display("FAIL rmid_ack: got %b want %b", ack, req); end
        n_cmp++; if (txreq !== txack) begin n_bad++; $display("FAIL rmid_txreq: got %b want %b", txreq, txack); end
        n_cmp++; if (owner !== 3'd0 || locked !== 1'b0) begin n_bad++; $display("FAIL rmid_state: got %0d/%b want 0/0", owner, locked); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (txreq !== txack || locked !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rmid_quiet: got %0d bad cycles want 0", bad); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL rmid_rx: got none want %h", e); end
            else begin g = rx_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL rmid_rx: got %h want %h", g, e); end end
        end
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL rmid_extra: got %0d extra want 0", rx_q.size()); end
        rx_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_line_lock();
        test_round_robin();
        test_timeout_vs_launch();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
